// File: rtl/knight_tour_solver.sv
// knight_tour_solver: DFS knight's tour on an NxN board; in: clk, rst_n, go, x_start, y_start, indx; out: move (one-hot at indx), busy, done, fail
module knight_tour_solver #(
  parameter int N = 5,
  parameter int IDX_W = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [2:0]       x_start,
  input  logic [2:0]       y_start,
  input  logic [IDX_W-1:0] indx,
  output logic [7:0]       move,
  output logic             busy,
  output logic             done,
  output logic             fail
);
  typedef enum logic [2:0] {IDLE, INIT, POSS, MOVE, BACKUP, DONE, FAIL} state_t;
  localparam logic signed [4:0] DX [8] = '{5'sd1, -5'sd1, -5'sd2, -5'sd2, -5'sd1, 5'sd1, 5'sd2, 5'sd2};
  localparam logic signed [4:0] DY [8] = '{5'sd2, 5'sd2, 5'sd1, -5'sd1, -5'sd2, -5'sd2, -5'sd1, 5'sd1};
  localparam logic signed [4:0] NS = 5'(N);
  localparam logic [3:0] NU = 4'(N);
  localparam logic [5:0] LAST = 6'(N * N - 1);
  state_t state, nxt;
  logic [63:0] visited;
  logic [7:0] stk [64];
  logic [5:0] cnt, cur_i, tgt_i, ri;
  logic [2:0] xx, yy, bx, by;
  logic [7:0] bound, poss, poss_c, above, cand, pick, bm;
  logic signed [4:0] px [8];
  logic signed [4:0] py [8];
  logic signed [4:0] tx, ty;
  logic accept, start_ok;
  function automatic logic signed [4:0] ddx(input logic [7:0] m);
    ddx = '0;
    for (int i = 0; i < 8; i++) if (m[i]) ddx = DX[i];
  endfunction
  function automatic logic signed [4:0] ddy(input logic [7:0] m);
    ddy = '0;
    for (int i = 0; i < 8; i++) if (m[i]) ddy = DY[i];
  endfunction
  assign accept   = go && (state == IDLE || state == DONE || state == FAIL);
  assign start_ok = ({1'b0, x_start} < NU) && ({1'b0, y_start} < NU);
  assign busy     = state == INIT || state == POSS || state == MOVE || state == BACKUP;
  assign done     = state == DONE;
  assign fail     = state == FAIL;
  assign ri       = 6'(indx);
  assign move     = (done && ri < LAST) ? stk[ri] : 8'h00;
  assign cur_i    = 6'(int'(yy) * N + int'(xx));
  // Candidate moves are checked in signed coordinates so off-board squares never index the board.
  always_comb begin
    poss_c = '0;
    for (int i = 0; i < 8; i++) begin
      px[i] = $signed({2'b00, xx}) + DX[i];
      py[i] = $signed({2'b00, yy}) + DY[i];
      if (px[i] >= 0 && px[i] < NS && py[i] >= 0 && py[i] < NS)
        poss_c[i] = !visited[6'(int'(py[i]) * N + int'(px[i]))];
    end
  end
  // A zero bound means a fresh square: every candidate is eligible.
  assign above = (bound == 8'h00) ? 8'hff : ~(bound | (bound - 8'd1));
  assign cand  = poss & above;
  assign pick  = cand & (~cand + 8'd1);
  assign tx    = $signed({2'b00, xx}) + ddx(pick);
  assign ty    = $signed({2'b00, yy}) + ddy(pick);
  assign tgt_i = 6'(int'(ty) * N + int'(tx));
  assign bm    = stk[cnt - 6'd1];
  assign bx    = xx - 3'(ddx(bm));
  assign by    = yy - 3'(ddy(bm));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, FAIL: nxt = accept ? (start_ok ? INIT : FAIL) : state;
      INIT:   nxt = (LAST == 6'd0) ? DONE : POSS;
      POSS:   nxt = MOVE;
      MOVE:   nxt = (pick != 8'h00) ? ((cnt + 6'd1 == LAST) ? DONE : POSS) : BACKUP;
      BACKUP: nxt = (cnt == 6'd0) ? FAIL : POSS;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      xx    <= '0;
      yy    <= '0;
      bound <= '0;
      poss  <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: if (accept) begin
          xx <= x_start;
          yy <= y_start;
        end
        INIT: begin
          cnt   <= '0;
          bound <= '0;
        end
        POSS: poss <= poss_c;
        MOVE: if (pick != 8'h00) begin
          xx    <= tx[2:0];
          yy    <= ty[2:0];
          cnt   <= cnt + 6'd1;
          bound <= '0;
        end
        BACKUP: if (cnt != 6'd0) begin
          xx    <= bx;
          yy    <= by;
          cnt   <= cnt - 6'd1;
          bound <= bm;
        end
        default: ;
      endcase
    end
  always_ff @(posedge clk)
    case (state)
      INIT: visited <= 64'd1 << cur_i;
      MOVE: if (pick != 8'h00) begin
        visited[tgt_i] <= 1'b1;
        stk[cnt]       <= pick;
      end
      BACKUP: if (cnt != 6'd0) visited[cur_i] <= 1'b0;
      default: ;
    endcase
endmodule

// File: tb/tb_knight_tour_solver.sv
// tb_knight_tour_solver: directed checks of knight_tour_solver for N=5, N=4 and N=1
module tb_knight_tour_solver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic go5, go4, go1;
  logic [2:0] x5, y5, x4, y4, x1, y1;
  logic [4:0] i5;
  logic [3:0] i4;
  logic [0:0] i1;
  logic [7:0] m5, m4, m1;
  logic busy5, done5, fail5, busy4, done4, fail4, busy1, done1, fail1;
  int tests = 0;
  int fails = 0;
  int tdx [8] = '{1, -1, -2, -2, -1, 1, 2, 2};
  int tdy [8] = '{2, 2, 1, -1, -2, -2, -1, 1};
  knight_tour_solver #(.N(5)) d5 (.clk(clk), .rst_n(rst_n), .go(go5), .x_start(x5), .y_start(y5),
    .indx(i5), .move(m5), .busy(busy5), .done(done5), .fail(fail5));
  knight_tour_solver #(.N(4)) d4 (.clk(clk), .rst_n(rst_n), .go(go4), .x_start(x4), .y_start(y4),
    .indx(i4), .move(m4), .busy(busy4), .done(done4), .fail(fail4));
  knight_tour_solver #(.N(1)) d1 (.clk(clk), .rst_n(rst_n), .go(go1), .x_start(x1), .y_start(y1),
    .indx(i1), .move(m1), .busy(busy1), .done(done1), .fail(fail1));
  task automatic start5(input logic [2:0] x, input logic [2:0] y);
    x5 = x;
    y5 = y;
    go5 = 1'b1;
    @(posedge clk); #1;
    go5 = 1'b0;
  endtask
  task automatic wait5(input string tag);
    int c = 0;
    while (busy5 && c < 300000) begin
      @(posedge clk); #1;
      c++;
    end
    tests++;
    if (busy5) begin
      fails++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, required 0", tag, busy5, c);
    end
  endtask
  task automatic check_tour5(input int sx, input int sy);
    bit vis [25];
    int x, y, nx, ny, k, seen;
    foreach (vis[j]) vis[j] = 1'b0;
    x = sx;
    y = sy;
    vis[y * 5 + x] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      i5 = 5'(i);
      #1;
      k = -1;
      for (int j = 0; j < 8; j++) if (m5 == (8'h01 << j)) k = j;
      tests++;
      if (k < 0) begin
        fails++;
        $display("FAIL tour(%0d,%0d) step %0d: move=%h, required one-hot", sx, sy, i, m5);
      end else begin
        nx = x + tdx[k];
        ny = y + tdy[k];
        if (nx < 0 || nx > 4 || ny < 0 || ny > 4 || vis[ny * 5 + nx]) begin
          fails++;
          $display("FAIL tour(%0d,%0d) step %0d: move=%h lands on (%0d,%0d), required on-board unvisited", sx, sy, i, m5, nx, ny);
        end else begin
          vis[ny * 5 + nx] = 1'b1;
          x = nx;
          y = ny;
        end
      end
    end
    seen = 0;
    foreach (vis[j]) seen += int'(vis[j]);
    tests++;
    if (seen != 25) begin
      fails++;
      $display("FAIL tour(%0d,%0d) coverage: %0d squares, required 25", sx, sy, seen);
    end
    i5 = 5'd24;
    #1;
    tests++;
    if (m5 !== 8'h00) begin
      fails++;
      $display("FAIL tour(%0d,%0d) indx24: move=%h, required 00", sx, sy, m5);
    end
  endtask
  task automatic test_reset;
    #12;
    tests++;
    if ({busy5, done5, fail5, m5, busy4, done4, fail4, m4, busy1, done1, fail1, m1} !== '0) begin
      fails++;
      $display("FAIL reset: d5=%b%b%b/%h d4=%b%b%b/%h d1=%b%b%b/%h, required all 0",
        busy5, done5, fail5, m5, busy4, done4, fail4, m4, busy1, done1, fail1, m1);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  task automatic test_n1;
    go1 = 1'b1;
    @(posedge clk); #1;
    go1 = 1'b0;
    tests++;
    if ({busy1, done1} !== 2'b10) begin
      fails++;
      $display("FAIL n1 edge1: busy,done=%b%b, required 10", busy1, done1);
    end
    @(posedge clk); #1;
    tests++;
    if ({busy1, done1, fail1, m1} !== {3'b010, 8'h00}) begin
      fails++;
      $display("FAIL n1 edge2: busy,done,fail=%b%b%b move=%h, required 010/00", busy1, done1, fail1, m1);
    end
  endtask
  task automatic test_bad_start;
    x5 = 3'd5;
    y5 = 3'd0;
    go5 = 1'b1;
    #1;
    tests++;
    if (busy5 !== 1'b0) begin
      fails++;
      $display("FAIL bad_start pre: busy=%b, required 0", busy5);
    end
    @(posedge clk); #1;
    go5 = 1'b0;
    tests++;
    if ({busy5, done5, fail5} !== 3'b001) begin
      fails++;
      $display("FAIL bad_start: busy,done,fail=%b%b%b, required 001", busy5, done5, fail5);
    end
  endtask
  task automatic test_tour_center;
    start5(3'd2, 3'd2);
    tests++;
    if ({busy5, done5, fail5} !== 3'b100) begin
      fails++;
      $display("FAIL center accept: busy,done,fail=%b%b%b, required 100", busy5, done5, fail5);
    end
    wait5("center");
    i5 = 5'd0;
    #1;
    tests++;
    if ({done5, fail5, m5} !== {2'b10, 8'h01}) begin
      fails++;
      $display("FAIL center result: done,fail=%b%b move0=%h, required 10/01", done5, fail5, m5);
    end
    check_tour5(2, 2);
  endtask
  task automatic test_odd_start;
    start5(3'd0, 3'd1);
    repeat (500) @(posedge clk);
    #1;
    tests++;
    if ({busy5, done5} !== 2'b10) begin
      fails++;
      $display("FAIL odd searching: busy,done=%b%b, required 10", busy5, done5);
    end
    for (int i = 0; i < 25; i += 6) begin
      i5 = 5'(i);
      #1;
      tests++;
      if (m5 !== 8'h00) begin
        fails++;
        $display("FAIL odd move[%0d]: %h while searching, required 00", i, m5);
      end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset_mid;
    start5(3'd2, 3'd2);
    repeat (40) @(posedge clk);
    #3;
    rst_n = 1'b0;
    i5 = 5'd0;
    #1;
    tests++;
    if ({busy5, done5, fail5, m5} !== 11'd0) begin
      fails++;
      $display("FAIL reset_mid: busy,done,fail=%b%b%b move=%h, required 000/00", busy5, done5, fail5, m5);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    start5(3'd0, 3'd0);
    wait5("restart");
    tests++;
    if ({done5, fail5} !== 2'b10) begin
      fails++;
      $display("FAIL restart result: done,fail=%b%b, required 10", done5, fail5);
    end
    check_tour5(0, 0);
  endtask
  task automatic test_back_to_back;
    start5(3'd2, 3'd2);
    x5 = 3'd4;
    y5 = 3'd4;
    go5 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    go5 = 1'b0;
    wait5("busy_go");
    i5 = 5'd0;
    #1;
    tests++;
    if ({done5, fail5, m5} !== {2'b10, 8'h01}) begin
      fails++;
      $display("FAIL busy_go result: done,fail=%b%b move0=%h, required 10/01", done5, fail5, m5);
    end
    check_tour5(2, 2);
    start5(3'd4, 3'd4);
    tests++;
    if ({busy5, done5} !== 2'b10) begin
      fails++;
      $display("FAIL corner accept: busy,done=%b%b, required 10", busy5, done5);
    end
    wait5("corner");
    i5 = 5'd0;
    #1;
    tests++;
    if (done5 !== 1'b1 || !(m5 inside {8'h02, 8'h04, 8'h08, 8'h10})) begin
      fails++;
      $display("FAIL corner result: done=%b move0=%h, required 1 and one of 02/04/08/10", done5, m5);
    end
    check_tour5(4, 4);
  endtask
  task automatic test_n4_fail;
    int c = 0;
    x4 = 3'd0;
    y4 = 3'd0;
    go4 = 1'b1;
    @(posedge clk); #1;
    go4 = 1'b0;
    while (busy4 && c < 300000) begin
      @(posedge clk); #1;
      c++;
    end
    i4 = 4'd0;
    #1;
    tests++;
    if ({busy4, done4, fail4, m4} !== {3'b001, 8'h00}) begin
      fails++;
      $display("FAIL n4: busy,done,fail=%b%b%b move0=%h after %0d cycles, required 001/00", busy4, done4, fail4, m4, c);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    {go5, go4, go1} = '0;
    {x5, y5, x4, y4, x1, y1} = '0;
    i5 = '0;
    i4 = '0;
    i1 = '0;
    test_reset;
    test_n1;
    test_bad_start;
    test_tour_center;
    test_odd_start;
    test_reset_mid;
    test_back_to_back;
    test_n4_fail;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/knight_tour_solver.md
# knight_tour_solver

Parametrised knight's-tour engine for an N×N board, successor to the fixed 5×5 tour logic. On `go` it runs a deterministic depth-first backtracking search from (`x_start`,`y_start`) and stores the resulting move list. The list is read back by index for the motion sequencer. Unlike the fixed-size block it:
- supports board sizes 1–8;
- reports an exhausted search (no tour) on `fail`;
- rejects out-of-range starts;
- exposes `busy`.

## Interface
- `N`, default 5: board side length, legal range 1..8.
- `IDX_W`, default `$clog2(N*N)` (minimum 1): width of `indx`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `go`  in  1  start request, sampled when not busy.
- `x_start`  in  3  start column, 0..N-1.
- `y_start`  in  3  start row, 0..N-1.
- `indx`  in  IDX_W  move-list read index.
- `move`  out  8  one-hot move at `indx`; 8'h00 if `indx` ≥ N*N-1 or no valid list.
- `busy`  out  1  search in progress.
- `done`  out  1  tour found, sticky.
- `fail`  out  1  no tour or bad start, sticky.

## Operation
- **Move encoding** (one-hot, as (dx,dy)):
  - bit0 (+1,+2), bit1 (-1,+2), bit2 (-2,+1), bit3 (-2,-1)
  - bit4 (-1,-2), bit5 (+1,-2), bit6 (+2,-1), bit7 (+2,+1)
- **Candidate order:** candidates are always tried LSB first. The result is therefore unique per (N, start).
- **Storage:**
  - N*N visited bits.
  - Move stack of N*N-1 entries × 8 bits.
  - Current position `xx`,`yy` (3 bits each).
  - Move counter `cnt` (0..N*N-1).
  - Per-level "tried" bound, recovered from the stack entry on backup.
- **IDLE**
  - `go`=1 with `x_start`<N and `y_start`<N → INIT.
  - `go`=1 with an out-of-range start → FAIL directly, with no search.
- **INIT**
  - Clear all visited bits, then mark the start square.
  - `cnt`=0; `xx`,`yy` = start.
  - Clear `done` and `fail`.
  - Next state: DONE if N*N-1 == 0, else POSS.
- **POSS:** register `poss` = all moves from (`xx`,`yy`) that land on-board and on an unvisited square.
- **MOVE:**
  - Pick the lowest `poss` bit strictly above the tried bound. The bound is 0 on fresh entry to a square.
  - If one exists:
    - push it into stack[`cnt`];
    - update `xx`,`yy` and mark the new square;
    - `cnt`++;
    - go to DONE if the new `cnt` == N*N-1, else POSS with the bound reset.
  - If none exists → BACKUP.
- **BACKUP:**
  - If `cnt`==0 → FAIL.
  - Otherwise:
    - unmark (`xx`,`yy`);
    - `cnt`--;
    - reverse stack[`cnt`] to restore `xx`,`yy`;
    - set the bound = stack[`cnt`];
    - go to POSS, then MOVE, which resumes above that bound.
- **DONE / FAIL:**
  - `done` or `fail` is held.
  - A new `go` is accepted exactly as in IDLE.
- **Read port:**
  - `move` is combinational from the stack and `indx`.
  - It is valid only while `done`=1; otherwise it is 8'h00.
- **`go` while `busy`** is ignored.
- **Arithmetic:** compute coordinates as signed 5-bit and check bounds against 0..N-1 before indexing the board.

## Timing
- **Reset values:** `busy`=0, `done`=0, `fail`=0, `move`=8'h00, state IDLE.
  - The stack and visited bits need no reset but must be cleared by INIT.
- **Async reset mid-search:** returns to IDLE immediately. Outputs go to the reset values; no partial result is visible.
- **Accepting `go`:** a `go` sampled high at edge k enters INIT. `busy`=1 from edge k through the edge entering DONE/FAIL.
- **Completion:** `done`/`fail` rise on the same edge that `busy` falls. Exactly one of them is high after any completion.
- **Restart from DONE/FAIL:** a new `go` clears `done`/`fail` on the INIT edge.
- **Per-state timing:** every state lasts exactly 1 cycle.
  - Forward step = 2 cycles (POSS + MOVE).
  - Backup = 3 cycles (BACKUP + POSS + MOVE).
- **Fast paths:**
  - N=1: `done` 2 edges after `go` is sampled.
  - Bad start: `fail` 1 edge after `go` is sampled.
- **Read latency:** `move` responds to `indx` in the same cycle (combinational).

## Test plan
- **N=5, start (2,2), pulse `go`:**
  - `done`=1, `fail`=0.
  - `move[0]`=8'h01.
  - Replaying `indx` 0..23 from (2,2) visits all 25 squares exactly once, every move one-hot and on-board.
  - `indx`=24 → 8'h00.
- **N=5, start (0,1)** (odd colour) → `fail`=1, `done`=0, `move`=8'h00 for all `indx`.
- **N=4, start (0,0)** → `fail`=1 after exhaustive search.
- **N=1, start (0,0):**
  - `done` exactly 2 edges after `go`.
  - **N=5, `x_start`=5:** `fail` 1 edge after `go`; `busy` never asserted.
- **N=5, start (2,2); assert `rst_n`=0 mid-search, then restart with start (0,0):**
  - Immediately after reset: all outputs 0.
  - Restart then completes with `done`=1 and a legal 24-move tour.
- **N=5; pulse `go` again while `busy`:** ignored, and the result is identical to the undisturbed run. Then `go` from DONE with start (4,4) gives a new legal tour with `move[0]` ∈ {bit1, bit2, bit3, bit4}.
